mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified RAM between two requesters: port 0 is the multi-cycle CPU (fetch and load/store), port 1 is the DMA/debug loader.
- Registered round-robin arbitration, with optional burst lock bounded by a starvation guard.
- Sits between the requesters and the ram instance and drives its addr/we/w_data; RAM read data is returned registered, one cycle after the access.

Parameters:
- ADDR_W, 32, address width of RAM and ports
- DATA_W, 32, data width
- MAX_BURST, 8, max consecutive locked accesses by one port while the other is requesting (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0  in  1  port 0 access request; hold addr0/we0/wdata0 stable until gnt0
- lock0  in  1  port 0 asks to keep ownership after the current access
- we0  in  1  port 0 write enable
- addr0  in  ADDR_W  port 0 byte address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 access performed this cycle
- rdata0  out  DATA_W  port 0 read data
- rvalid0  out  1  rdata0 valid
- req1, lock1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same meanings and widths for port 1
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates occur on posedge clk.
- FSM states: ArbIdle, ArbServe0, ArbServe1.
- gnt0 = (state==ArbServe0) & req0; gnt1 = (state==ArbServe1) & req1. A cycle with gntX=1 is exactly one RAM access.
- RAM drive in ArbServeX: ram_addr=addrX, ram_wdata=wdataX, ram_we=gntX & weX.
- RAM drive in ArbIdle: ram_addr=0, ram_wdata=0, ram_we=0.
- Read return: on any gnt cycle with we=0, rdataX <= ram_rdata and rvalidX <= 1 at that edge. Data is therefore valid in the cycle after gnt. rvalidX is a single-cycle pulse; rdataX holds its value until the next read. Writes produce no rvalid.
- Latency:
  - From ArbIdle, req in cycle N gives gnt in N+1 and rdata in N+2.
  - Back-to-back: ownership may move directly ArbServe0 <-> ArbServe1 with no idle cycle.
- Arbitration function (evaluated in ArbIdle, and at the end of every ArbServe cycle):
  - Neither port requesting -> ArbIdle.
  - Exactly one port requesting -> that port's serve state.
  - Both requesting -> the port that was not served last (pointer last_port).
- Lock/burst rules in ArbServeX when gntX=1:
  - lockX=1, and either the other port is not requesting or burst_cnt < MAX_BURST-1 -> stay, burst_cnt++.
  - Otherwise -> re-run the arbitration function with last_port=X, and clear burst_cnt.
  - Without lock, a sole requester continues back-to-back.
- Owner drops req while in ArbServeX (no gnt) -> re-arbitrate the same cycle and clear burst_cnt.
- The lock counter never wraps: it saturates at MAX_BURST-1.
- Simultaneous events:
  - Both req asserted on the same cycle from ArbIdle -> the round-robin pointer decides.
  - After reset, last_port=1, so port 0 wins the first tie.
- Reset, including mid-operation: state=ArbIdle, burst_cnt=0, last_port=1, rvalid0=rvalid1=0, rdata0=rdata1=0, gnt0=gnt1=0, ram_we=0. An access in flight is dropped and its rvalid is suppressed.
- Requesters must not change addr/we/wdata while req is high and gnt is low; the arbiter does not check this.

Decomposition:
- Package ArbPkg holds:
  - typedef enum logic [1:0] arb_state_t {ArbIdle, ArbServe0, ArbServe1}
  - localparam port ids Port0=0, Port1=1
  - function rr_pick(req0, req1, last_port) returning the next state
- No sub-module. The datapath mux and return registers are inline; the FSM and burst counter live in one always_ff.

Test Plan:
- Reset, then req0 read of addr 0x10 (RAM holds 0xDEADBEEF) -> gnt0 in cycle 2, rvalid0=1 with rdata0=0xDEADBEEF in cycle 3; gnt1 and rvalid1 stay 0.
- req0 and req1 asserted together, both unlocked, repeatedly -> grants alternate 0,1,0,1 with no idle cycle; port 0 gets the first grant.
- MAX_BURST=4, port 1 holds lock1 with continuous writes while req0 is high -> exactly 4 consecutive gnt1, then gnt0, then port 1 is served again.
- lock0 held with req1 low -> unlimited back-to-back gnt0; burst_cnt saturates and no forced switch occurs.
- Port 1 writes 0x12345678 to 0x40, then port 0 reads 0x40 -> ram_we pulses for exactly one cycle, rdata0=0x12345678.
- reset asserted in the gnt cycle of a port 0 read -> next cycle state ArbIdle, rvalid0=0, ram_we=0, and re-arbitration restarts with port 0 priority.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the round-robin decision for the two-port RAM arbiter.
package ArbPkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbServe0 = 2'd1,
    ArbServe1 = 2'd2
  } arb_state_t;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  // Next owner: a sole requester wins; on a tie the port not served last wins.
  function automatic arb_state_t rr_pick(input logic req0, input logic req1,
                                         input logic last_port);
    if (req0 && req1) return (last_port == Port0) ? ArbServe1 : ArbServe0;
    else if (req0)    return ArbServe0;
    else if (req1)    return ArbServe1;
    else              return ArbIdle;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port unified RAM: registered
// round-robin ownership with a bounded burst lock and registered read return.
module mem_port_arbiter
  import ArbPkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_port;

  assign gnt0 = (state == ArbServe0) && req0;
  assign gnt1 = (state == ArbServe1) && req1;

  // Ownership FSM, burst counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ArbIdle;
      burst_cnt <= '0;
      last_port <= Port1;
    end else begin
      case (state)
        ArbIdle: state <= rr_pick(req0, req1, last_port);
        ArbServe0: begin
          if (gnt0) begin
            last_port <= Port0;
            if (lock0 && (!req1 || burst_cnt < BURST_MAX)) begin
              if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state     <= rr_pick(req0, req1, Port0);
              burst_cnt <= '0;
            end
          end else begin
            state     <= rr_pick(req0, req1, last_port);
            burst_cnt <= '0;
          end
        end
        ArbServe1: begin
          if (gnt1) begin
            last_port <= Port1;
            if (lock1 && (!req0 || burst_cnt < BURST_MAX)) begin
              if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state     <= rr_pick(req0, req1, Port1);
              burst_cnt <= '0;
            end
          end else begin
            state     <= rr_pick(req0, req1, last_port);
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= ArbIdle;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // RAM drive follows the current owner; idle drives zeros.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state)
      ArbServe0: begin
        ram_addr  = addr0;
        ram_wdata = wdata0;
        ram_we    = gnt0 & we0;
      end
      ArbServe1: begin
        ram_addr  = addr1;
        ram_wdata = wdata1;
        ram_we    = gnt1 & we1;
      end
      default: ;
    endcase
  end

  // Registered read return: one-cycle rvalid pulse, rdata held until next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= ram_rdata;
      if (gnt1 && !we1) rdata1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, lock0, we0, req1, lock1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [31:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;

  logic [31:0] ram [256];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[9:2]];
  always @(posedge clk) if (ram_we) ram[ram_addr[9:2]] <= ram_wdata;

  // Reference model: who owns the RAM, how long the current locked run is,
  // who was served last, and a shadow copy of memory.
  int          m_owner;   // -1 none, 0 or 1
  int          m_run;
  int          m_last;
  logic [31:0] mmem [256];
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  bit          mdl_g0, mdl_g1, obs_g0, obs_g1, obs_we;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One clock cycle: compare at negedge, advance the model, return after posedge.
  task automatic step();
    bit g0, g1, g, lk, oreq, ew;
    logic [31:0] ea, ed;
    @(negedge clk);
    g0 = (m_owner == 0) && req0;
    g1 = (m_owner == 1) && req1;
    ea = (m_owner == 0) ? addr0 : (m_owner == 1) ? addr1 : 32'd0;
    ed = (m_owner == 0) ? wdata0 : (m_owner == 1) ? wdata1 : 32'd0;
    ew = (g0 && we0) || (g1 && we1);
    check_eq("gnt0", gnt0, g0);
    check_eq("gnt1", gnt1, g1);
    check_eq("ram_we", ram_we, ew);
    check_eq("ram_addr", ram_addr, ea);
    check_eq("ram_wdata", ram_wdata, ed);
    check_eq("rvalid0", rvalid0, m_rv0);
    check_eq("rvalid1", rvalid1, m_rv1);
    check_eq("rdata0", rdata0, m_rd0);
    check_eq("rdata1", rdata1, m_rd1);
    obs_g0 = gnt0; obs_g1 = gnt1; obs_we = ram_we;
    mdl_g0 = g0;   mdl_g1 = g1;
    if (reset) begin
      m_owner = -1; m_run = 0; m_last = 1;
      m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = g0 && !we0;
      m_rv1 = g1 && !we1;
      if (m_rv0) m_rd0 = mmem[ea[9:2]];
      if (m_rv1) m_rd1 = mmem[ea[9:2]];
      if (m_owner < 0) begin
        m_owner = pick(req0, req1, m_last);
      end else begin
        g    = (m_owner == 0) ? g0 : g1;
        lk   = (m_owner == 0) ? lock0 : lock1;
        oreq = (m_owner == 0) ? req1 : req0;
        if (g) begin
          m_last = m_owner;
          if (lk && (!oreq || m_run < MAXB - 1)) begin
            if (m_run < MAXB - 1) m_run++;
          end else begin
            m_owner = pick(req0, req1, m_last);
            m_run = 0;
          end
        end else begin
          m_owner = pick(req0, req1, m_last);
          m_run = 0;
        end
      end
    end
    if (ew) mmem[ea[9:2]] = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; lock0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic new_txn(input int p);
    if (p == 0) begin
      req0 = 1; we0 = $urandom_range(0, 1); addr0 = {22'd0, 8'($urandom), 2'b00}; wdata0 = $urandom;
    end else begin
      req1 = 1; we1 = $urandom_range(0, 1); addr1 = {22'd0, 8'($urandom), 2'b00}; wdata1 = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  streak, cnt;
    int  seq [12];
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; ram[i] = v; mmem[i] = v;
    end
    ram[4] = 32'hDEADBEEF; mmem[4] = 32'hDEADBEEF;
    m_owner = -1; m_run = 0; m_last = 1;
    m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    step();
    reset = 0;

    // Single read from idle: gnt one cycle after req, data the cycle after.
    req0 = 1; addr0 = 32'h10; we0 = 0;
    step();
    check_eq("t1_idle_gnt0", obs_g0, 0);
    step();
    check_eq("t1_gnt0", obs_g0, 1);
    check_eq("t1_gnt1", obs_g1, 0);
    check_eq("t1_rvalid0", rvalid0, 1);
    check_eq("t1_rdata0", rdata0, 32'hDEADBEEF);
    check_eq("t1_rvalid1", rvalid1, 0);
    req0 = 0;
    step();
    step();

    // Unlocked tie: strict alternation starting with port 0.
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'h20; addr1 = 32'h24;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t2_alt_g0", obs_g0, (k % 2) == 0);
      check_eq("t2_alt_g1", obs_g1, (k % 2) == 1);
    end

    // Locked burst by port 1 capped at MAX_BURST while port 0 waits.
    do_reset();
    req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h80; wdata1 = 32'hA5A5A5A5;
    step();
    req0 = 1; addr0 = 32'h84;
    for (int k = 0; k < 12; k++) begin
      step();
      seq[k] = obs_g1 ? 1 : (obs_g0 ? 0 : -1);
    end
    streak = 0;
    while (streak < 12 && seq[streak] == 1) streak++;
    check_eq("t3_burst_len", streak, MAXB);
    check_eq("t3_then_port0", seq[MAXB], 0);
    check_eq("t3_back_port1", seq[MAXB + 1], 1);

    // Lock with no contender: unlimited back-to-back, saturated counter.
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 32'h30;
    step();
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      step();
      if (obs_g0) cnt++;
    end
    check_eq("t4_run_len", cnt, 11);
    req1 = 1; addr1 = 32'h34;
    step();
    check_eq("t4_last_g0", obs_g0, 1);
    step();
    check_eq("t4_switch_g1", obs_g1, 1);

    // Write through port 1, read back through port 0.
    do_reset();
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h12345678;
    cnt = 0;
    step();
    if (obs_we) cnt++;
    step();
    if (obs_we) cnt++;
    check_eq("t5_wr_gnt1", obs_g1, 1);
    req1 = 0; we1 = 0; req0 = 1; addr0 = 32'h40;
    step();
    if (obs_we) cnt++;
    step();
    if (obs_we) cnt++;
    check_eq("t5_rd_gnt0", obs_g0, 1);
    check_eq("t5_we_pulses", cnt, 1);
    check_eq("t5_rdata0", rdata0, 32'h12345678);
    req0 = 0;
    step();

    // Reset landing on a port 0 read grant.
    do_reset();
    req0 = 1; addr0 = 32'h10;
    step();
    reset = 1;
    step();
    check_eq("t6_gnt_at_reset", obs_g0, 1);
    reset = 0;
    check_eq("t6_rvalid0", rvalid0, 0);
    req1 = 1; addr1 = 32'h14;
    step();
    check_eq("t6_idle_g0", obs_g0, 0);
    check_eq("t6_idle_we", obs_we, 0);
    step();
    check_eq("t6_prio_g0", obs_g0, 1);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 0;
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) new_txn(0);
      end else if (mdl_g0) begin
        if ($urandom_range(0, 3) == 0) req0 = 0; else new_txn(0);
      end else if ($urandom_range(0, 31) == 0) req0 = 0;
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) new_txn(1);
      end else if (mdl_g1) begin
        if ($urandom_range(0, 3) == 0) req1 = 0; else new_txn(1);
      end else if ($urandom_range(0, 31) == 0) req1 = 0;
      lock0 = ($urandom_range(0, 2) == 0);
      lock1 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) reset = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
